// File: rtl/serial_frame_tx_if.sv
// Request bundle for the serial frame transmitter.
// The requester holds len/data stable until the block accepts.
interface serial_frame_tx_if #(
  parameter int PAY_W = 16,
  parameter int HDR_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [HDR_W-1:0] in_len;
  logic [PAY_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_len,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_len,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Serialises one payload word per handshake as flag, length header,
// LSB-first payload and an idle-high gap for the sequence detector.
module serial_frame_tx #(
  parameter int PAY_W    = 16,
  parameter int HDR_W    = 5,
  parameter int IDLE_GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_frame_tx_if.slave   in_if,
  output logic               ser_out_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               len_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_HDR,
    S_PAY,
    S_GAP
  } state_e;

  localparam int M1    = (PAY_W > 7) ? PAY_W : 7;
  localparam int M2    = (M1 > HDR_W) ? M1 : HDR_W;
  localparam int MAXC  = (M2 > IDLE_GAP) ? M2 : IDLE_GAP;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] FLAG_LAST = CNT_W'(6);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP - 1);
  localparam logic [HDR_W-1:0] LEN_MAX   = HDR_W'(PAY_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HDR_W-1:0] len_q, len_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [PAY_W-1:0] sh_q, sh_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lerr_q, lerr_d;

  logic             accept;
  logic             clamp;
  logic [HDR_W-1:0] leff;
  logic [CNT_W-1:0] len_c;
  logic [CNT_W-1:0] lend_c;

  assign in_if.in_ready = (state_q == S_IDLE);
  assign accept = in_if.in_valid && (state_q == S_IDLE);
  assign clamp  = in_if.in_len > LEN_MAX;
  assign leff   = clamp ? LEN_MAX : in_if.in_len;
  assign len_c  = CNT_W'(len_q);
  assign lend_c = CNT_W'(len_d);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    len_d   = len_q;
    hdr_d   = hdr_q;
    sh_d    = sh_q;
    lerr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = S_FLAG;
          len_d   = leff;
          hdr_d   = leff;
          sh_d    = in_if.in_data;
          lerr_d  = clamp;
        end
      end
      S_FLAG: begin
        if (cnt_q == FLAG_LAST) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        if (cnt_q == HDR_LAST) begin
          state_d = (len_q != '0) ? S_PAY : S_GAP;
          cnt_d   = '0;
        end else begin
          hdr_d = hdr_q << 1;
        end
      end
      S_PAY: begin
        sh_d = sh_q >> 1;
        if (cnt_q == len_c - 1'b1) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up
  // with the bit the state register will be presenting.
  always_comb begin
    ser_d  = 1'b1;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    unique case (1'b1)
      (state_d == S_FLAG): begin
        ser_d = !((cnt_d == '0) || (cnt_d == FLAG_LAST));
      end
      (state_d == S_HDR): begin
        ser_d  = hdr_d[HDR_W-1];
        done_d = (cnt_d == HDR_LAST) && (len_d == '0);
      end
      (state_d == S_PAY): begin
        ser_d  = sh_d[0];
        done_d = (cnt_d == lend_c - 1'b1);
      end
      default: begin
        ser_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      sh_q    <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
    end
  end

  assign ser_out_o    = ser_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign len_err_o    = lerr_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed and randomised frames checked bit-by-bit against a
// frame-format reference built from the flag/header/payload/gap rules.
module tb_serial_frame_tx;
  localparam int PAY_W    = 16;
  localparam int HDR_W    = 5;
  localparam int IDLE_GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.PAY_W(PAY_W), .HDR_W(HDR_W)) bus ();

  logic ser, busy, done, lerr;

  serial_frame_tx #(
    .PAY_W(PAY_W),
    .HDR_W(HDR_W),
    .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_if(bus.slave),
    .ser_out_o(ser),
    .busy_o(busy),
    .frame_done_o(done),
    .len_err_o(lerr)
  );

  int tests = 0;
  int fails = 0;
  bit exp_q[$];
  int nframe;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line contents from the accept+1 cycle to the end of the gap.
  task automatic build(input int len, input logic [15:0] data);
    int leff;
    int flag [7] = '{0, 1, 1, 1, 1, 1, 0};
    leff = (len > PAY_W) ? PAY_W : len;
    exp_q.delete();
    foreach (flag[k]) exp_q.push_back(flag[k][0]);
    for (int b = HDR_W - 1; b >= 0; b--) exp_q.push_back(((leff >> b) & 1) != 0);
    for (int i = 0; i < leff; i++) exp_q.push_back(data[i]);
    nframe = exp_q.size();
    for (int g = 0; g < IDLE_GAP; g++) exp_q.push_back(1'b1);
  endtask

  task automatic run_frame(input int len, input logic [15:0] data,
                           input bit hold, input bit scramble,
                           input string tag);
    build(len, data);
    bus.in_valid = 1'b1;
    bus.in_len   = len[4:0];
    bus.in_data  = data;
    chk({tag, ".ready_pre"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, ".ser"}, {31'd0, ser}, {31'd0, exp_q[i]});
      chk({tag, ".done"}, {31'd0, done}, (i == nframe - 1) ? 32'd1 : 32'd0);
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, ".lerr"}, {31'd0, lerr},
          (i == 0 && len > PAY_W) ? 32'd1 : 32'd0);
      if (scramble) begin
        bus.in_data = 16'($urandom);
        bus.in_len  = 5'($urandom);
      end
      @(negedge clk);
    end
    chk({tag, ".ready_post"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, ".busy_post"}, {31'd0, busy}, 32'd0);
    chk({tag, ".ser_post"}, {31'd0, ser}, 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_len   = '0;
    bus.in_data  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("RST.ser", {31'd0, ser}, 32'd1);
    chk("RST.ready", {31'd0, bus.in_ready}, 32'd1);
    chk("RST.busy", {31'd0, busy}, 32'd0);
    chk("RST.done", {31'd0, done}, 32'd0);
    chk("RST.lerr", {31'd0, lerr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(3, 16'h0005, 1'b0, 1'b0, "T2");
    run_frame(0, 16'h1234, 1'b0, 1'b0, "T3");
    run_frame(16, 16'hFFFF, 1'b0, 1'b0, "T4");
    run_frame(20, 16'hA5A5, 1'b0, 1'b0, "T5");

    // Reset in the middle of the payload aborts the frame at once.
    bus.in_valid = 1'b1;
    bus.in_len   = 5'd16;
    bus.in_data  = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("T1.in_pay", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("T1.ser", {31'd0, ser}, 32'd1);
    chk("T1.ready", {31'd0, bus.in_ready}, 32'd1);
    chk("T1.busy", {31'd0, busy}, 32'd0);
    chk("T1.done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("T1.ser_after", {31'd0, ser}, 32'd1);
    chk("T1.busy_after", {31'd0, busy}, 32'd0);
    run_frame(7, 16'h5A3C, 1'b0, 1'b0, "T1R");

    repeat (8) begin
      run_frame(int'($urandom_range(0, 20)), 16'($urandom),
                1'b1, 1'b1, "T6");
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    repeat (12) begin
      run_frame(int'($urandom_range(0, 31)), 16'($urandom),
                1'b0, 1'b0, "RND");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
